mips_multicycle_seq: RTL and testbench

- Multi-cycle control sequencer for the MIPS datapath: register file, ALU, ALU control, data memory and the three 2:1 muxes.
- Replaces the newInstruction-pulse FSM with a clocked valid/ready instruction handshake.
- Steps each accepted instruction through DECODE/EXEC/MEM/WB and emits all datapath control strobes.
- Adds a data-memory acknowledge with timeout, illegal-instruction detection and a retired-instruction counter.

---
 rtl/mips_multicycle_seq.sv | 177 +++++++++++++++++
 tb/tb_mips_multicycle_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_seq.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_seq
// Brief    : Multi-cycle MIPS control sequencer with valid/ready fetch,
//            memory-ack timeout, illegal decode and retired-instruction count.
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_seq #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    input  logic             mem_ack,
    output logic             ir_load,
    output logic             reg_dst,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             mem_to_reg,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             done,
    output logic             illegal,
    output logic             timeout,
    output logic             busy,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [5:0] C_OP_RTYPE  = 6'h00;
    localparam logic [5:0] C_OP_LW     = 6'h23;
    localparam logic [5:0] C_OP_SW     = 6'h2B;
    localparam logic [7:0] C_WAIT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       ready_q, busy_q;
    logic       reg_dst_q, alu_src_q, mem_to_reg_q;
    logic [1:0] alu_op_q;
    logic       mem_read_q, mem_write_q, reg_write_q;
    logic       done_q, illegal_q, timeout_q;

    logic w_op_r, w_op_lw, w_op_sw, w_funct_ok, w_legal, w_static_en;
    logic w_unused_ir;

    // Only opcode and funct steer the sequence; the register fields belong to the datapath.
    assign w_unused_ir = ^ir_q[25:6];

    always_comb begin
        w_op_r  = (ir_q[31:26] == C_OP_RTYPE);
        w_op_lw = (ir_q[31:26] == C_OP_LW);
        w_op_sw = (ir_q[31:26] == C_OP_SW);
        case (ir_q[5:0])
            6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A: w_funct_ok = 1'b1;
            default:                                  w_funct_ok = 1'b0;
        endcase
        w_legal = (w_op_r & w_funct_ok) | w_op_lw | w_op_sw;
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        wait_d  = wait_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = w_legal ? S_EXEC : S_ERR;
            S_EXEC: begin
                if (w_op_r) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_MEM;
                    wait_d  = 8'd0;
                end
            end
            S_MEM: begin
                // An ack arriving on the final allowed cycle still wins over the abort.
                if (mem_ack) begin
                    state_d = w_op_lw ? S_WB : S_DONE;
                end else if (wait_q == C_WAIT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB:   state_d = S_DONE;
            S_DONE: begin
                cnt_d   = cnt_q + C_CNT_ONE;
                state_d = S_IDLE;
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign w_static_en = (state_d == S_EXEC) || (state_d == S_MEM) ||
                         (state_d == S_WB)   || (state_d == S_DONE);

    // Outputs are registered from the next state so each strobe lines up with its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ir_q         <= 32'd0;
            wait_q       <= 8'd0;
            cnt_q        <= '0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            reg_dst_q    <= 1'b0;
            alu_src_q    <= 1'b0;
            alu_op_q     <= 2'd0;
            mem_to_reg_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            wait_q       <= wait_d;
            cnt_q        <= cnt_d;
            ready_q      <= (state_d == S_IDLE);
            busy_q       <= (state_d != S_IDLE);
            reg_dst_q    <= w_static_en & w_op_r;
            alu_src_q    <= w_static_en & ~w_op_r;
            alu_op_q     <= (w_static_en & w_op_r) ? 2'd2 : 2'd0;
            mem_to_reg_q <= w_static_en & w_op_lw;
            mem_read_q   <= (state_d == S_MEM) & w_op_lw;
            mem_write_q  <= (state_d == S_MEM) & w_op_sw;
            reg_write_q  <= (state_d == S_WB);
            done_q       <= (state_d == S_DONE);
            illegal_q    <= (state_d == S_ERR) & (state_q == S_DECODE);
            timeout_q    <= (state_d == S_ERR) & (state_q == S_MEM);
        end
    end

    // ir_load qualifies the handshake cycle itself so the datapath latches on the same edge as IR.
    assign ir_load     = ready_q & instr_valid & ~rst;
    assign instr_ready = ready_q;
    assign busy        = busy_q;
    assign reg_dst     = reg_dst_q;
    assign alu_src     = alu_src_q;
    assign alu_op      = alu_op_q;
    assign mem_to_reg  = mem_to_reg_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign reg_write   = reg_write_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign timeout     = timeout_q;
    assign instr_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_seq
// Brief    : Cycle-accurate timeline model of the sequencer, directed and
//            randomized instruction streams.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_seq;

    localparam int T  = 15;
    localparam int CW = 16;

    localparam int B_RDY = 13, B_LD = 12, B_BSY = 11, B_DST = 10, B_SRC = 9;
    localparam int B_OP1 = 8, B_M2R = 6, B_MRD = 5, B_MWR = 4;
    localparam int B_RW = 3, B_DONE = 2, B_ILL = 1, B_TMO = 0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          instr_valid = 1'b0;
    logic [31:0]   instr = 32'd0;
    logic          mem_ack = 1'b0;
    logic          instr_ready, ir_load, reg_dst, alu_src, mem_to_reg;
    logic [1:0]    alu_op;
    logic          mem_read, mem_write, reg_write, done, illegal, timeout, busy;
    logic [CW-1:0] instr_count;

    mips_multicycle_seq #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .mem_ack(mem_ack), .ir_load(ir_load), .reg_dst(reg_dst),
        .alu_src(alu_src), .alu_op(alu_op), .mem_to_reg(mem_to_reg),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .done(done), .illegal(illegal), .timeout(timeout), .busy(busy),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // One expected output vector per future cycle; ack: 0 drive low, 1 drive high, 2 random.
    typedef struct packed {
        logic [13:0] o;
        logic [1:0]  ack;
    } step_t;

    step_t       plan[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int unsigned model_cnt = 0;
    bit          last_acc = 1'b0;
    int          t_acc, t_done, t_ill, t_tmo, t_dst, t_rw, t_rdy;
    int          n_rw, n_mrd, n_mwr, n_done, n_tmo;

    function automatic logic [13:0] bit1(input int b);
        return 14'(1) << b;
    endfunction

    function automatic void push(input logic [13:0] o, input logic [1:0] a);
        step_t s;
        s.o   = o;
        s.ack = a;
        plan.push_back(s);
    endfunction

    // Expand an accepted instruction into its cycle-by-cycle output timeline.
    function automatic void enqueue(input logic [31:0] ins, input int d);
        logic [5:0]  op, fn;
        bit          is_r, is_lw, is_sw;
        logic [13:0] bsy, s, m;
        int          nmem;
        op    = ins[31:26];
        fn    = ins[5:0];
        is_r  = (op == 6'h00) && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                                  fn == 6'h25 || fn == 6'h27 || fn == 6'h2A);
        is_lw = (op == 6'h23);
        is_sw = (op == 6'h2B);
        bsy   = bit1(B_BSY);
        push(bsy, 2'd2);
        if (!(is_r || is_lw || is_sw)) begin
            push(bsy | bit1(B_ILL), 2'd2);
            return;
        end
        s = bsy | (is_r ? (bit1(B_DST) | bit1(B_OP1)) : bit1(B_SRC)) |
            (is_lw ? bit1(B_M2R) : 14'd0);
        push(s, 2'd2);
        if (is_r) begin
            push(s | bit1(B_RW), 2'd2);
            push(s | bit1(B_DONE), 2'd2);
            return;
        end
        m    = s | (is_lw ? bit1(B_MRD) : bit1(B_MWR));
        nmem = (d < T) ? d + 1 : T;
        for (int i = 0; i < nmem; i++)
            push(m, (d < T && i == d) ? 2'd1 : 2'd0);
        if (d >= T) begin
            push(bsy | bit1(B_TMO), 2'd2);
        end else begin
            if (is_lw) push(s | bit1(B_RW), 2'd2);
            push(s | bit1(B_DONE), 2'd2);
        end
    endfunction

    task automatic clr_obs();
        t_acc = -1; t_done = -1; t_ill = -1; t_tmo = -1; t_dst = -1; t_rw = -1; t_rdy = -1;
        n_rw = 0; n_mrd = 0; n_mwr = 0; n_done = 0; n_tmo = 0;
    endtask

    task automatic chk(input string name, input int got, input int exp_v);
        checks++;
        if (got != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp_v);
        end
    endtask

    // One clock: drive inputs after the edge, compare against the model at the falling edge.
    task automatic tick(input bit v, input logic [31:0] ins, input bit r, input int d);
        step_t       s;
        bit          have;
        logic [13:0] exp_o, obs;
        have = 1'b0;
        s    = '0;
        @(posedge clk);
        #1;
        cyc++;
        rst         = r;
        instr_valid = v;
        instr       = ins;
        last_acc    = 1'b0;
        if (r) begin
            plan.delete();
            model_cnt = 0;
            exp_o     = bit1(B_RDY);
            mem_ack   = 1'($urandom);
        end else if (plan.size() != 0) begin
            s       = plan.pop_front();
            have    = 1'b1;
            exp_o   = s.o;
            mem_ack = (s.ack == 2'd2) ? 1'($urandom) : s.ack[0];
        end else begin
            exp_o    = bit1(B_RDY) | (v ? bit1(B_LD) : 14'd0);
            last_acc = v;
            mem_ack  = 1'($urandom);
        end
        @(negedge clk);
        obs = {instr_ready, ir_load, busy, reg_dst, alu_src, alu_op, mem_to_reg,
               mem_read, mem_write, reg_write, done, illegal, timeout};
        checks++;
        if (obs !== exp_o) begin
            errors++;
            $display("FAIL outputs cycle %0d: got %h, expected %h", cyc, obs, exp_o);
        end
        checks++;
        if (instr_count !== CW'(model_cnt)) begin
            errors++;
            $display("FAIL instr_count cycle %0d: got %0d, expected %0d", cyc, instr_count, CW'(model_cnt));
        end
        if (obs[B_LD]) t_acc = cyc;
        if (obs[B_DONE]) begin t_done = cyc; n_done++; end
        if (obs[B_ILL]) t_ill = cyc;
        if (obs[B_TMO]) begin t_tmo = cyc; n_tmo++; end
        if (obs[B_DST] && t_dst < 0) t_dst = cyc;
        if (obs[B_RW]) begin t_rw = cyc; n_rw++; end
        if (obs[B_MRD]) n_mrd++;
        if (obs[B_MWR]) n_mwr++;
        if (obs[B_RDY] && t_acc >= 0 && cyc > t_acc && t_rdy < 0) t_rdy = cyc;
        if (have && s.o[B_DONE]) model_cnt++;
        if (last_acc) enqueue(ins, d);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, $urandom, 1'b0, 0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [5:0]  fl[6];
        fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        w  = $urandom;
        case ($urandom_range(0, 4))
            0: w = {6'h00, w[25:6], fl[$urandom_range(0, 5)]};
            1: w = {6'h23, w[25:0]};
            2: w = {6'h2B, w[25:0]};
            3: w = {6'h00, w[25:0]};
            default: ;
        endcase
        return w;
    endfunction

    logic [31:0] prog[3];
    int          idx, guard;

    initial begin
        clr_obs();
        tick(1'b0, 32'd0, 1'b1, 0);
        tick(1'b0, 32'd0, 1'b1, 0);
        idle(1);
        chk("reset count", int'(instr_count), 0);
        chk("reset ready", int'(instr_ready), 1);

        clr_obs();
        tick(1'b1, 32'h00221820, 1'b0, 0);
        idle(6);
        chk("add reg_dst start", t_dst - t_acc, 2);
        chk("add reg_write cycle", t_rw - t_acc, 3);
        chk("add reg_write count", n_rw, 1);
        chk("add done latency", t_done - t_acc, 4);
        chk("add instr_count", int'(instr_count), 1);

        clr_obs();
        tick(1'b1, 32'h8C050004, 1'b0, 3);
        idle(10);
        chk("lw mem_read cycles", n_mrd, 4);
        chk("lw reg_write cycle", t_rw - t_acc, 7);
        chk("lw done latency", t_done - t_acc, 8);
        chk("lw instr_count", int'(instr_count), 2);

        clr_obs();
        tick(1'b1, 32'hAC050008, 1'b0, 0);
        idle(6);
        chk("sw mem_write cycles", n_mwr, 1);
        chk("sw reg_write count", n_rw, 0);
        chk("sw done latency", t_done - t_acc, 4);
        chk("sw instr_count", int'(instr_count), 3);

        prog = '{32'h10000000, 32'h00000000, 32'h0};
        for (int k = 0; k < 2; k++) begin
            clr_obs();
            tick(1'b1, prog[k], 1'b0, 0);
            idle(4);
            chk("illegal pulse cycle", t_ill - t_acc, 2);
            chk("illegal done count", n_done, 0);
            chk("illegal ready back", t_rdy - t_acc, 3);
            chk("illegal instr_count", int'(instr_count), 3);
        end

        clr_obs();
        tick(1'b1, 32'h8C050004, 1'b0, 99);
        idle(20);
        chk("timeout mem_read cycles", n_mrd, 15);
        chk("timeout pulse cycle", t_tmo - t_acc, 18);
        chk("timeout reg_write count", n_rw, 0);
        chk("timeout instr_count", int'(instr_count), 3);

        clr_obs();
        tick(1'b1, 32'h8C050004, 1'b0, 14);
        idle(22);
        chk("late ack mem_read cycles", n_mrd, 15);
        chk("late ack timeout count", n_tmo, 0);
        chk("late ack done latency", t_done - t_acc, 19);
        chk("late ack instr_count", int'(instr_count), 4);

        clr_obs();
        prog  = '{32'h012A4020, 32'h8D090010, 32'hAD090014};
        idx   = 0;
        guard = 0;
        while (idx < 2 && guard < 40) begin
            tick(1'b1, prog[idx], 1'b0, (idx == 1) ? 200 : 0);
            if (last_acc) idx++;
            guard++;
        end
        chk("b2b accepted", idx, 2);
        repeat (4) tick(1'b1, prog[2], 1'b0, 0);
        chk("b2b first retired", n_done, 1);
        tick(1'b1, prog[2], 1'b1, 0);
        tick(1'b1, prog[2], 1'b1, 0);
        chk("b2b count after rst", int'(instr_count), 0);
        tick(1'b1, prog[2], 1'b0, 0);
        chk("b2b third accepted", int'(last_acc), 1);
        idle(6);
        chk("b2b third retired", int'(instr_count), 1);

        repeat (3000) begin
            bit          v, r;
            logic [31:0] ins;
            int          d;
            ins = rand_instr();
            v   = ($urandom_range(0, 9) < 7);
            r   = ($urandom_range(0, 299) == 0);
            case ($urandom_range(0, 9))
                0:       d = 13;
                1:       d = 14;
                2:       d = 15;
                3:       d = 40;
                default: d = $urandom_range(0, 4);
            endcase
            tick(v, ins, r, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
